// File: rtl/cp0_except_ctrl_pkg.sv
// CP0 shared definitions: register numbers, excepttype codes, ExcCode values
// and Status/Cause field positions.
package cp0_except_ctrl_pkg;

    // MFC0/MTC0 register numbers
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // Encoded excepttype bus codes (1..8 are IP0..IP7)
    localparam logic [3:0] ET_NONE    = 4'h0;
    localparam logic [3:0] ET_INT0    = 4'h1;
    localparam logic [3:0] ET_INT7    = 4'h8;
    localparam logic [3:0] ET_SYSCALL = 4'h9;
    localparam logic [3:0] ET_RI      = 4'ha;
    localparam logic [3:0] ET_OV      = 4'hb;
    localparam logic [3:0] ET_ADEL    = 4'hc;
    localparam logic [3:0] ET_ERET    = 4'hd;

    // Cause.ExcCode values
    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;

    // Status fields
    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;

    // Cause fields
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    // Map an exception code (1..0xc) to its Cause.ExcCode value
    function automatic logic [4:0] map_exccode(input logic [3:0] code);
        logic [4:0] exc;
        exc = EXCCODE_INT;
        case (code)
            ET_SYSCALL: exc = EXCCODE_SYS;
            ET_RI:      exc = EXCCODE_RI;
            ET_OV:      exc = EXCCODE_OV;
            ET_ADEL:    exc = EXCCODE_ADEL;
            default:    exc = EXCCODE_INT;
        endcase
        return exc;
    endfunction

endpackage

// File: rtl/cp0_except_ctrl_if.sv
// Exception bus between the MEM-stage encoder (master) and CP0 (slave).
interface cp0_except_ctrl_if;
    logic [31:0] excepttype_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [31:0] bad_vaddr_i;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport master (
        output excepttype_i, pc_i, in_delayslot_i, bad_vaddr_i,
        input  flush_o, new_pc_o
    );

    modport slave (
        input  excepttype_i, pc_i, in_delayslot_i, bad_vaddr_i,
        output flush_o, new_pc_o
    );
endinterface

// File: rtl/cp0_except_ctrl_timer.sv
// CP0 Count/Compare timer with sticky Count==Compare interrupt.
module cp0_except_ctrl_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    // Free-running counter; an MTC0 Count write overrides the increment
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (count_we) begin
            count <= wdata;
        end else begin
            count <= count + 32'd1;
        end
    end

    // Compare register and sticky match flag; writing Compare clears it with priority
    always_ff @(posedge clk) begin
        if (rst) begin
            compare   <= '0;
            timer_int <= 1'b0;
        end else if (compare_we) begin
            compare   <= wdata;
            timer_int <= 1'b0;
        end else if (count == compare && compare != '0) begin
            timer_int <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_except_ctrl.sv
// CP0 exception controller: owns Status/Cause/EPC/BadVAddr, commits exceptions
// and ERET, redirects the pipeline and serves MTC0/MFC0.
module cp0_except_ctrl
    import cp0_except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int unsigned TIMER_IP   = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    cp0_except_ctrl_if.slave         exc,
    input  logic [5:0]               hw_int_i,
    input  logic                     we_i,
    input  logic [4:0]               waddr_i,
    input  logic [31:0]              wdata_i,
    input  logic [4:0]               raddr_i,
    output logic [31:0]              rdata_o,
    output logic [31:0]              status_o,
    output logic [31:0]              cause_o,
    output logic [31:0]              epc_o,
    output logic                     timer_int_o
);

    localparam logic [2:0] TIMER_BIT = TIMER_IP[2:0];

    logic [31:0] status_q, cause_q, epc_q, badvaddr_q;
    logic [31:0] count, compare, epc_target;
    logic [3:0]  code;
    logic [7:0]  ip_next;
    logic        is_exc, is_eret, epc_wr, ctrl_we, unused_hi;

    assign code      = exc.excepttype_i[3:0];
    assign unused_hi = |exc.excepttype_i[31:4];

    // Decode the code, gate MTC0 against a same-cycle exception/ERET, build the redirect
    always_comb begin
        is_exc       = (code >= ET_INT0) && (code <= ET_ADEL);
        is_eret      = (code == ET_ERET);
        epc_wr       = we_i && (waddr_i == REG_EPC);
        ctrl_we      = we_i && !is_exc && !is_eret;
        epc_target   = exc.in_delayslot_i ? exc.pc_i - 32'd4 : exc.pc_i;
        exc.flush_o  = is_exc || is_eret;
        exc.new_pc_o = '0;
        if (is_exc) begin
            exc.new_pc_o = EXC_VECTOR;
        end else if (is_eret) begin
            exc.new_pc_o = epc_wr ? wdata_i : epc_q;
        end
    end

    // Next Cause.IP: hardware lines, software bits (MTC0), timer ORed in
    always_comb begin
        ip_next = {hw_int_i, cause_q[CAUSE_IP_LO+1:CAUSE_IP_LO]};
        if (ctrl_we && waddr_i == REG_CAUSE) begin
            ip_next[1:0] = wdata_i[CAUSE_IP_LO+1:CAUSE_IP_LO];
        end
        if (timer_int_o) begin
            ip_next[TIMER_BIT] = 1'b1;
        end
    end

    // CP0 state: exception commit beats ERET beats MTC0; ERET still lets an EPC write through
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= '0;
            cause_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            cause_q[CAUSE_IP_HI:CAUSE_IP_LO] <= ip_next;
            if (is_exc) begin
                status_q[STATUS_EXL]               <= 1'b1;
                cause_q[CAUSE_EXC_HI:CAUSE_EXC_LO] <= map_exccode(code);
                if (!status_q[STATUS_EXL]) begin
                    epc_q             <= epc_target;
                    cause_q[CAUSE_BD] <= exc.in_delayslot_i;
                end
                if (code == ET_ADEL) begin
                    badvaddr_q <= exc.bad_vaddr_i;
                end
            end else if (is_eret) begin
                status_q[STATUS_EXL] <= 1'b0;
                if (epc_wr) begin
                    epc_q <= wdata_i;
                end
            end else if (we_i) begin
                case (waddr_i)
                    REG_STATUS: begin
                        status_q[STATUS_IM_HI:STATUS_IM_LO] <= wdata_i[STATUS_IM_HI:STATUS_IM_LO];
                        status_q[STATUS_EXL]                <= wdata_i[STATUS_EXL];
                        status_q[STATUS_IE]                 <= wdata_i[STATUS_IE];
                    end
                    REG_EPC: epc_q <= wdata_i;
                    default: ;
                endcase
            end
        end
    end

    cp0_except_ctrl_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (ctrl_we && waddr_i == REG_COUNT),
        .compare_we (ctrl_we && waddr_i == REG_COMPARE),
        .wdata      (wdata_i),
        .count      (count),
        .compare    (compare),
        .timer_int  (timer_int_o)
    );

    // MFC0 read mux of registered values
    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            REG_BADVADDR: rdata_o = badvaddr_q;
            REG_COUNT:    rdata_o = count;
            REG_COMPARE:  rdata_o = compare;
            REG_STATUS:   rdata_o = status_q;
            REG_CAUSE:    rdata_o = cause_q;
            REG_EPC:      rdata_o = epc_q;
            default:      rdata_o = '0;
        endcase
    end

    assign status_o = status_q;
    assign cause_o  = cause_q;
    assign epc_o    = epc_q;

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Directed self-checking bench for cp0_except_ctrl.
module tb_cp0_except_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hw_int_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o, status_o, cause_o, epc_o;
    logic        timer_int_o;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    cp0_except_ctrl_if bus ();

    cp0_except_ctrl #(.EXC_VECTOR(32'h0000_0020), .TIMER_IP(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .exc         (bus),
        .hw_int_i    (hw_int_i),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .raddr_i     (raddr_i),
        .rdata_o     (rdata_o),
        .status_o    (status_o),
        .cause_o     (cause_o),
        .epc_o       (epc_o),
        .timer_int_o (timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.excepttype_i   = 32'h0;
        bus.in_delayslot_i = 1'b0;
        we_i               = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        step();
        we_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); hw_int_i = '0; waddr_i = '0; wdata_i = '0; raddr_i = 5'd9;
        bus.pc_i = '0; bus.bad_vaddr_i = '0;
        step(); step();
        rst = 1'b0; #1;
        n_cmp++; if (status_o !== 32'h0) begin n_bad++; $display("FAIL reset_status got=%h exp=%h", status_o, 32'h0); end
        n_cmp++; if (cause_o !== 32'h0) begin n_bad++; $display("FAIL reset_cause got=%h exp=%h", cause_o, 32'h0); end
        n_cmp++; if (epc_o !== 32'h0) begin n_bad++; $display("FAIL reset_epc got=%h exp=%h", epc_o, 32'h0); end
        n_cmp++; if (bus.flush_o !== 1'b0 || bus.new_pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_flush got=%b/%h exp=0/0", bus.flush_o, bus.new_pc_o); end
        n_cmp++; if (timer_int_o !== 1'b0) begin n_bad++; $display("FAIL reset_timer got=%b exp=0", timer_int_o); end
        n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL reset_count got=%h exp=%h", rdata_o, 32'h0); end
        step();
        n_cmp++; if (rdata_o !== 32'h1) begin n_bad++; $display("FAIL count_start got=%h exp=%h", rdata_o, 32'h1); end
    endtask

    task automatic test_exc_vector();
        bus.excepttype_i = 32'hb; bus.pc_i = 32'h100; bus.in_delayslot_i = 1'b0; #1;
        n_cmp++; if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'h20) begin n_bad++; $display("FAIL ov_redirect got=%b/%h exp=1/00000020", bus.flush_o, bus.new_pc_o); end
        step(); idle(); #1;
        n_cmp++; if (epc_o !== 32'h100) begin n_bad++; $display("FAIL ov_epc got=%h exp=%h", epc_o, 32'h100); end
        n_cmp++; if (cause_o !== 32'h30) begin n_bad++; $display("FAIL ov_cause got=%h exp=%h", cause_o, 32'h30); end
        n_cmp++; if (status_o !== 32'h2) begin n_bad++; $display("FAIL ov_status got=%h exp=%h", status_o, 32'h2); end
    endtask

    task automatic test_delayslot();
        bus.excepttype_i = 32'hd; step();
        bus.excepttype_i = 32'h9; bus.pc_i = 32'h204; bus.in_delayslot_i = 1'b1; step(); idle(); #1;
        n_cmp++; if (epc_o !== 32'h200) begin n_bad++; $display("FAIL ds_epc got=%h exp=%h", epc_o, 32'h200); end
        n_cmp++; if (cause_o !== 32'h8000_0020) begin n_bad++; $display("FAIL ds_cause got=%h exp=%h", cause_o, 32'h8000_0020); end
        bus.excepttype_i = 32'hb; bus.pc_i = 32'h500; step(); idle(); #1;
        n_cmp++; if (epc_o !== 32'h200) begin n_bad++; $display("FAIL nested_epc got=%h exp=%h", epc_o, 32'h200); end
        n_cmp++; if (cause_o !== 32'h8000_0030) begin n_bad++; $display("FAIL nested_cause got=%h exp=%h", cause_o, 32'h8000_0030); end
    endtask

    task automatic test_eret();
        bus.excepttype_i = 32'hd; step(); idle();
        mtc0(5'd14, 32'h300);
        bus.excepttype_i = 32'hd; #1;
        n_cmp++; if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'h300) begin n_bad++; $display("FAIL eret_pc got=%b/%h exp=1/00000300", bus.flush_o, bus.new_pc_o); end
        step(); idle(); #1;
        n_cmp++; if (status_o !== 32'h0) begin n_bad++; $display("FAIL eret_status got=%h exp=%h", status_o, 32'h0); end
        bus.excepttype_i = 32'hd; we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h400; #1;
        n_cmp++; if (bus.new_pc_o !== 32'h400) begin n_bad++; $display("FAIL eret_bypass got=%h exp=%h", bus.new_pc_o, 32'h400); end
        step(); idle(); #1;
        n_cmp++; if (epc_o !== 32'h400) begin n_bad++; $display("FAIL eret_epc_wr got=%h exp=%h", epc_o, 32'h400); end
        n_cmp++; if (cause_o !== 32'h8000_0030) begin n_bad++; $display("FAIL eret_cause got=%h exp=%h", cause_o, 32'h8000_0030); end
    endtask

    task automatic test_other_codes();
        bus.excepttype_i = 32'he; #1;
        n_cmp++; if (bus.flush_o !== 1'b0 || bus.new_pc_o !== 32'h0) begin n_bad++; $display("FAIL code_e got=%b/%h exp=0/0", bus.flush_o, bus.new_pc_o); end
        step();
        bus.excepttype_i = 32'h1; bus.pc_i = 32'h700; we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'hFF01; #1;
        n_cmp++; if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'h20) begin n_bad++; $display("FAIL int_redirect got=%b/%h exp=1/00000020", bus.flush_o, bus.new_pc_o); end
        step(); idle(); #1;
        n_cmp++; if (status_o !== 32'h2) begin n_bad++; $display("FAIL int_mtc0_drop got=%h exp=%h", status_o, 32'h2); end
        n_cmp++; if (epc_o !== 32'h700 || cause_o !== 32'h0) begin n_bad++; $display("FAIL int_commit got=%h/%h exp=00000700/00000000", epc_o, cause_o); end
        bus.excepttype_i = 32'hd; step();
        bus.excepttype_i = 32'hc; bus.pc_i = 32'h800; bus.bad_vaddr_i = 32'hDEAD_BEEF; step(); idle();
        raddr_i = 5'd8; #1;
        n_cmp++; if (rdata_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL adel_badvaddr got=%h exp=%h", rdata_o, 32'hDEAD_BEEF); end
        n_cmp++; if (cause_o !== 32'h10) begin n_bad++; $display("FAIL adel_cause got=%h exp=%h", cause_o, 32'h10); end
        bus.excepttype_i = 32'hd; step(); idle();
    endtask

    task automatic test_hw_int();
        hw_int_i = 6'b100001; #1;
        n_cmp++; if (cause_o[15:8] !== 8'h00) begin n_bad++; $display("FAIL hwint_latency got=%h exp=%h", cause_o[15:8], 8'h00); end
        step();
        n_cmp++; if (cause_o[15:8] !== 8'h84) begin n_bad++; $display("FAIL hwint_ip got=%h exp=%h", cause_o[15:8], 8'h84); end
        hw_int_i = '0; step();
        n_cmp++; if (cause_o[15:8] !== 8'h00) begin n_bad++; $display("FAIL hwint_clear got=%h exp=%h", cause_o[15:8], 8'h00); end
    endtask

    task automatic test_timer();
        mtc0(5'd11, 32'h5);
        mtc0(5'd9, 32'h0);
        raddr_i = 5'd9; #1;
        n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL count_write got=%h exp=%h", rdata_o, 32'h0); end
        repeat (5) step();
        n_cmp++; if (rdata_o !== 32'h5 || timer_int_o !== 1'b0) begin n_bad++; $display("FAIL timer_pre got=%h/%b exp=00000005/0", rdata_o, timer_int_o); end
        step();
        n_cmp++; if (timer_int_o !== 1'b1 || cause_o[15] !== 1'b0) begin n_bad++; $display("FAIL timer_set got=%b/%b exp=1/0", timer_int_o, cause_o[15]); end
        step();
        n_cmp++; if (timer_int_o !== 1'b1 || cause_o[15] !== 1'b1) begin n_bad++; $display("FAIL timer_ip7 got=%b/%b exp=1/1", timer_int_o, cause_o[15]); end
        raddr_i = 5'd11; #1;
        n_cmp++; if (rdata_o !== 32'h5) begin n_bad++; $display("FAIL compare_read got=%h exp=%h", rdata_o, 32'h5); end
        mtc0(5'd11, 32'h1000);
        n_cmp++; if (timer_int_o !== 1'b0) begin n_bad++; $display("FAIL timer_clear got=%b exp=0", timer_int_o); end
        step();
        n_cmp++; if (cause_o[15] !== 1'b0) begin n_bad++; $display("FAIL ip7_clear got=%b exp=0", cause_o[15]); end
    endtask

    task automatic test_mtc0_fields();
        mtc0(5'd12, 32'hFFFF_FFFF);
        raddr_i = 5'd12; #1;
        n_cmp++; if (rdata_o !== 32'h0000_FF03) begin n_bad++; $display("FAIL status_mask got=%h exp=%h", rdata_o, 32'h0000_FF03); end
        mtc0(5'd12, 32'h0);
        mtc0(5'd8, 32'h1234);
        raddr_i = 5'd8; #1;
        n_cmp++; if (rdata_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL badvaddr_ro got=%h exp=%h", rdata_o, 32'hDEAD_BEEF); end
        mtc0(5'd13, 32'hFFFF_FFFF);
        n_cmp++; if (cause_o !== 32'h0000_0310) begin n_bad++; $display("FAIL cause_mask got=%h exp=%h", cause_o, 32'h0000_0310); end
        raddr_i = 5'd10; #1;
        n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL unmapped_reg got=%h exp=%h", rdata_o, 32'h0); end
        mtc0(5'd9, 32'hFFFF_FFFF);
        raddr_i = 5'd9; #1;
        n_cmp++; if (rdata_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL count_max got=%h exp=%h", rdata_o, 32'hFFFF_FFFF); end
        step();
        n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL count_wrap got=%h exp=%h", rdata_o, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_exc_vector();
        test_delayslot();
        test_eret();
        test_other_codes();
        test_hw_int();
        test_timer();
        test_mtc0_fields();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
